// File: rtl/hack_data_mem_map_if.sv
// CPU data-port bundle between the Hack CPU and the data memory map.
interface hack_data_mem_map_if;
  logic [14:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        stall;

  // CPU side drives address/strobe/data and receives read data and hold.
  modport master (
    output addressM,
    output writeM,
    output outM,
    input  inM,
    input  stall
  );

  // Memory-map side.
  modport slave (
    input  addressM,
    input  writeM,
    input  outM,
    output inM,
    output stall
  );
endinterface

// File: rtl/hack_data_mem_map.sv
// Hack data-memory address decoder: routes CPU data accesses to RAM,
// a screen write FIFO and the keyboard register, and aligns read data
// to the RAM's one-cycle read latency.
module hack_data_mem_map #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SCREEN_BASE = 16384,
  parameter int KBD_ADDR    = 24576
) (
  input  logic                 clk,
  input  logic                 reset,
  hack_data_mem_map_if.slave   cpu,
  output logic [13:0]          ram_addr,
  output logic                 ram_wr,
  output logic [15:0]          ram_din,
  input  logic [15:0]          ram_dout,
  output logic                 scr_valid,
  input  logic                 scr_ready,
  output logic [12:0]          scr_addr,
  output logic [15:0]          scr_data,
  input  logic [15:0]          kbd_code,
  input  logic                 kbd_strobe
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [15:0] SCR_LO      = 16'(SCREEN_BASE);
  localparam logic [15:0] SCR_HI      = 16'(SCREEN_BASE + 8191);
  localparam logic [14:0] SCR_BASE15  = 15'(SCREEN_BASE);
  localparam logic [14:0] KBD_A       = 15'(KBD_ADDR);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_KBD  = 2'd2
  } sel_t;

  // ---------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------
  logic        ram_sel;
  logic        scr_sel;
  logic        kbd_sel;
  logic [15:0] addr_ext;
  logic [12:0] scr_offset;

  assign addr_ext   = {1'b0, cpu.addressM};
  assign ram_sel    = ~cpu.addressM[14];
  assign scr_sel    = (addr_ext >= SCR_LO) && (addr_ext <= SCR_HI);
  assign kbd_sel    = (cpu.addressM == KBD_A);
  assign scr_offset = 13'(cpu.addressM - SCR_BASE15);

  // ---------------------------------------------------------------
  // Screen write FIFO (first-word-fall-through)
  // ---------------------------------------------------------------
  logic [28:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Full is derived from registered occupancy only, so stall never
  // depends combinationally on scr_ready.
  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);
  assign push  = cpu.writeM & scr_sel & ~full;
  assign pop   = ~empty & scr_ready;

  // Entry storage: each slot captures a push aimed at its index.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_slot
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          fifo_mem[gi] <= {scr_offset, cpu.outM};
        end
      end
    end
  endgenerate

  // Occupancy update for simultaneous push/pop.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers; reset discards queued writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign scr_valid = ~empty;
  assign scr_addr  = fifo_mem[rd_ptr_reg][28:16];
  assign scr_data  = fifo_mem[rd_ptr_reg][15:0];

  // ---------------------------------------------------------------
  // CPU hold and RAM path
  // ---------------------------------------------------------------
  assign cpu.stall = cpu.writeM & scr_sel & full;
  assign ram_addr  = cpu.addressM[13:0];
  assign ram_din   = cpu.outM;
  assign ram_wr    = cpu.writeM & ram_sel & ~cpu.stall;

  // ---------------------------------------------------------------
  // Keyboard register and read-return alignment
  // ---------------------------------------------------------------
  logic [15:0] kbd_reg;
  logic [15:0] kbd_q_reg;
  sel_t        sel_q_reg;
  sel_t        sel_next;

  // Source selection for the read that returns next cycle.
  always_comb begin
    sel_next = SEL_ZERO;
    if (ram_sel)      sel_next = SEL_RAM;
    else if (kbd_sel) sel_next = SEL_KBD;
  end

  // Latest scan code; a zero code means the key was released.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_reg <= '0;
    end else if (kbd_strobe) begin
      kbd_reg <= kbd_code;
    end
  end

  // Capture read source and keyboard value alongside the RAM's own
  // registered read so all three line up on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q_reg <= SEL_ZERO;
      kbd_q_reg <= '0;
    end else begin
      sel_q_reg <= sel_next;
      kbd_q_reg <= kbd_reg;
    end
  end

  // Read data mux; screen and unmapped reads return zero.
  always_comb begin
    cpu.inM = 16'h0000;
    case (sel_q_reg)
      SEL_RAM: cpu.inM = ram_dout;
      SEL_KBD: cpu.inM = kbd_q_reg;
      default: cpu.inM = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_hack_data_mem_map.sv
// Directed testbench for hack_data_mem_map with a behavioural RAM.
module tb_hack_data_mem_map;

  logic        clk;
  logic        reset;
  logic [13:0] ram_addr;
  logic        ram_wr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic        scr_valid;
  logic        scr_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic [15:0] kbd_code;
  logic        kbd_strobe;

  int checks;
  int failures;
  int ram_wr_count;

  hack_data_mem_map_if bus ();

  hack_data_mem_map #(
    .FIFO_DEPTH (4),
    .SCREEN_BASE(16384),
    .KBD_ADDR   (24576)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (bus.slave),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .scr_valid (scr_valid),
    .scr_ready (scr_ready),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data),
    .kbd_code  (kbd_code),
    .kbd_strobe(kbd_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read.
  logic [15:0] ram_model [0:16383];
  always @(posedge clk) begin
    if (ram_wr) ram_model[ram_addr] <= ram_din;
    ram_dout <= ram_model[ram_addr];
  end

  // Count RAM write pulses seen at clock edges.
  always @(posedge clk) begin
    if (reset) ram_wr_count <= 0;
    else if (ram_wr) ram_wr_count <= ram_wr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [14:0] a, input logic w, input logic [15:0] d);
    bus.addressM = a;
    bus.writeM   = w;
    bus.outM     = d;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    scr_ready = 1'b0;
    kbd_code = 16'h0000;
    kbd_strobe = 1'b0;
    drive(15'd0, 1'b0, 16'h0000);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    check("reset_inM", 32'(bus.inM), 32'h0);
    check("reset_scr_valid", 32'(scr_valid), 32'h0);
    check("reset_stall", 32'(bus.stall), 32'h0);

    // RAM write then read back
    drive(15'd256, 1'b1, 16'd1110);
    #1;
    check("ram_wr_on_write", 32'(ram_wr), 32'h1);
    check("ram_addr_256", 32'(ram_addr), 32'd256);
    check("stall_ram_write", 32'(bus.stall), 32'h0);
    cyc();
    drive(15'd256, 1'b0, 16'h0000);
    #1;
    check("ram_wr_on_read", 32'(ram_wr), 32'h0);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("ram_read_256", 32'(bus.inM), 32'd1110);
    check("ram_wr_pulse_count", 32'(ram_wr_count), 32'd1);

    // Screen writes with the video controller ready
    scr_ready = 1'b1;
    drive(15'd16384, 1'b1, 16'hAAAA);
    #1;
    check("scr_w0_stall", 32'(bus.stall), 32'h0);
    check("scr_w0_ram_wr", 32'(ram_wr), 32'h0);
    cyc();
    drive(15'd16385, 1'b1, 16'h5555);
    #1;
    check("scr_beat0_valid", 32'(scr_valid), 32'h1);
    check("scr_beat0", {3'b0, scr_addr, scr_data}, {3'b0, 13'd0, 16'hAAAA});
    check("scr_w1_ram_wr", 32'(ram_wr), 32'h0);
    cyc();
    drive(15'd24575, 1'b1, 16'hFFFF);
    #1;
    check("scr_beat1", {3'b0, scr_addr, scr_data}, {3'b0, 13'd1, 16'h5555});
    check("scr_w2_ram_wr", 32'(ram_wr), 32'h0);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("scr_beat2", {3'b0, scr_addr, scr_data}, {3'b0, 13'd8191, 16'hFFFF});
    cyc();
    check("scr_drained", 32'(scr_valid), 32'h0);

    // Fill the FIFO, then a fifth write must stall
    scr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(15'(16384 + i), 1'b1, 16'(16'h1000 + i));
      #1;
      check($sformatf("fill_stall_%0d", i), 32'(bus.stall), 32'h0);
      cyc();
    end
    drive(15'd16388, 1'b1, 16'h1004);
    #1;
    check("write5_stall", 32'(bus.stall), 32'h1);
    check("write5_ram_wr", 32'(ram_wr), 32'h0);
    cyc();
    scr_ready = 1'b1;
    #1;
    check("pop_cycle_stall", 32'(bus.stall), 32'h1);
    check("pop_cycle_head", {3'b0, scr_addr, scr_data}, {3'b0, 13'd0, 16'h1000});
    cyc();
    scr_ready = 1'b0;
    #1;
    check("after_pop_stall", 32'(bus.stall), 32'h0);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    scr_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      check($sformatf("drain_valid_%0d", i), 32'(scr_valid), 32'h1);
      check($sformatf("drain_beat_%0d", i), {3'b0, scr_addr, scr_data},
            {3'b0, 13'(i), 16'(16'h1000 + i)});
      cyc();
    end
    check("drain_empty", 32'(scr_valid), 32'h0);

    // Keyboard register
    kbd_code = 16'd75;
    kbd_strobe = 1'b1;
    cyc();
    kbd_strobe = 1'b0;
    drive(15'd24576, 1'b0, 16'h0000);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("kbd_read_75", 32'(bus.inM), 32'd75);
    cyc();
    kbd_code = 16'd0;
    kbd_strobe = 1'b1;
    cyc();
    kbd_strobe = 1'b0;
    drive(15'd24576, 1'b0, 16'h0000);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("kbd_read_released", 32'(bus.inM), 32'd0);
    cyc();
    drive(15'd24576, 1'b1, 16'd99);
    #1;
    check("kbd_write_ram_wr", 32'(ram_wr), 32'h0);
    check("kbd_write_stall", 32'(bus.stall), 32'h0);
    cyc();
    check("kbd_write_no_fifo", 32'(scr_valid), 32'h0);
    drive(15'd24576, 1'b0, 16'h0000);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("kbd_read_after_write", 32'(bus.inM), 32'd0);
    cyc();

    // Unmapped and screen reads; seed aliased RAM words with non-zero data
    drive(15'd13616, 1'b1, 16'h7777);
    cyc();
    drive(15'd16, 1'b1, 16'h6666);
    cyc();
    drive(15'd30000, 1'b1, 16'd1234);
    #1;
    check("unmapped_w_ram_wr", 32'(ram_wr), 32'h0);
    check("unmapped_w_stall", 32'(bus.stall), 32'h0);
    cyc();
    check("unmapped_w_fifo", 32'(scr_valid), 32'h0);
    drive(15'd30000, 1'b0, 16'h0000);
    cyc();
    drive(15'd16400, 1'b0, 16'h0000);
    #1;
    check("unmapped_read", 32'(bus.inM), 32'h0);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("screen_read", 32'(bus.inM), 32'h0);
    check("ram_wr_total", 32'(ram_wr_count), 32'd3);
    cyc();

    // Reset mid-operation discards queued screen writes
    scr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(15'(16394 + i), 1'b1, 16'(16'h2000 + i));
      cyc();
    end
    check("prefill_valid", 32'(scr_valid), 32'h1);
    drive(15'd256, 1'b0, 16'h0000);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("rst_mid_scr_valid", 32'(scr_valid), 32'h0);
    check("rst_mid_stall", 32'(bus.stall), 32'h0);
    check("rst_mid_inM", 32'(bus.inM), 32'h0);
    drive(15'd16500, 1'b1, 16'hBEEF);
    #1;
    check("post_rst_w_stall", 32'(bus.stall), 32'h0);
    cyc();
    drive(15'd0, 1'b0, 16'h0000);
    #1;
    check("post_rst_beat", {3'b0, scr_addr, scr_data}, {3'b0, 13'd116, 16'hBEEF});
    scr_ready = 1'b1;
    cyc();
    check("post_rst_sole_entry", 32'(scr_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
